// File: rtl/spi_frame_slave.sv
// rtl/spi_frame_slave.sv - SPI mode-0 frame slave with header check and error counting
//
// Moves one BUFFER_SIZE-bit frame per chip-select window. MOSI is shifted into
// rx_shift on SCLK rising edges. tx_data, latched at chip-select fall, is shifted
// out MSB first on MISO, updating on SCLK falling edges. When chip select rises,
// the frame is accepted only if exactly BUFFER_SIZE bits arrived and the
// byte-reassembled header equals MSGID.
//
// Ports:
//   clk        system clock (>= 4x SCLK)
//   rst_n      asynchronous active-low reset
//   mosi       host data in
//   miso       device data out, driven continuously
//   sclk       SPI clock, idle low
//   sel        chip select, active low
//   tx_data    frame to transmit, MSB first
//   rx_data    last accepted frame, MSB first
//   sync       one-cycle pulse per accepted frame
//   frame_err  one-cycle pulse per rejected frame
//   err_count  saturating count of rejected frames
module spi_frame_slave #(
    parameter int          BUFFER_SIZE = 168,
    parameter logic [31:0] MSGID       = 32'h74697277,
    parameter int          SYNC_STAGES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mosi,
    output logic                   miso,
    input  logic                   sclk,
    input  logic                   sel,
    input  logic [BUFFER_SIZE-1:0] tx_data,
    output logic [BUFFER_SIZE-1:0] rx_data,
    output logic                   sync,
    output logic                   frame_err,
    output logic [7:0]             err_count
);

    localparam int              CW   = $clog2(BUFFER_SIZE + 1);
    localparam logic [CW-1:0]   FULL = CW'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Synchroniser chains; index 0 is the stage nearest the pin.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sel_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    state_t                 state_q, state_d;
    logic [BUFFER_SIZE-1:0] rx_shift_q, rx_shift_d;
    logic [BUFFER_SIZE-1:0] tx_shift_q, tx_shift_d;
    logic [BUFFER_SIZE-1:0] rx_data_q, rx_data_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    // Set when a rising SCLK edge arrives after the counter has saturated,
    // so an overlong frame fails the exact-count rule.
    logic                   over_q, over_d;
    logic                   miso_q, miso_d;
    logic                   sync_q, sync_d;
    logic                   ferr_q, ferr_d;
    logic [7:0]             err_cnt_q, err_cnt_d;

    logic        sclk_rise, sclk_fall, sel_rise, sel_fall, mosi_s;
    logic [31:0] hdr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            sel_sync_q  <= '1;
            mosi_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], sel};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign sclk_rise = sclk_sync_q[SYNC_STAGES-2] & ~sclk_sync_q[SYNC_STAGES-1];
    assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-2] & sclk_sync_q[SYNC_STAGES-1];
    assign sel_rise  = sel_sync_q[SYNC_STAGES-2] & ~sel_sync_q[SYNC_STAGES-1];
    assign sel_fall  = ~sel_sync_q[SYNC_STAGES-2] & sel_sync_q[SYNC_STAGES-1];
    // MOSI is stable for many clk cycles around the SCLK edge, so the final
    // stage is safe to sample.
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

    // The first byte on the wire lands in the least significant header byte.
    assign hdr = {rx_shift_q[BUFFER_SIZE-25 -: 8], rx_shift_q[BUFFER_SIZE-17 -: 8],
                  rx_shift_q[BUFFER_SIZE-9 -: 8],  rx_shift_q[BUFFER_SIZE-1 -: 8]};

    always_comb begin
        state_d    = state_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        over_d     = over_q;
        miso_d     = miso_q;
        sync_d     = 1'b0;
        ferr_d     = 1'b0;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (sel_fall) begin
                    tx_shift_d = tx_data;
                    bit_cnt_d  = '0;
                    over_d     = 1'b0;
                    miso_d     = tx_data[BUFFER_SIZE-1];
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[BUFFER_SIZE-2:0], mosi_s};
                    if (bit_cnt_q == FULL) begin
                        over_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (bit_cnt_q < FULL) begin
                        tx_shift_d = tx_shift_q << 1;
                        miso_d     = tx_shift_q[BUFFER_SIZE-2];
                    end else begin
                        miso_d = 1'b0;
                    end
                end
                if (sel_rise) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((bit_cnt_q == FULL) && !over_q && (hdr == MSGID)) begin
                    rx_data_d = rx_shift_q;
                    sync_d    = 1'b1;
                end else begin
                    ferr_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            over_q     <= 1'b0;
            miso_q     <= 1'b0;
            sync_q     <= 1'b0;
            ferr_q     <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            over_q     <= over_d;
            miso_q     <= miso_d;
            sync_q     <= sync_d;
            ferr_q     <= ferr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign miso      = miso_q;
    assign rx_data   = rx_data_q;
    assign sync      = sync_q;
    assign frame_err = ferr_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// tb/tb_spi_frame_slave.sv - randomized self-checking bench for spi_frame_slave
module tb_spi_frame_slave;

    localparam int          B    = 48;
    localparam logic [31:0] MID  = 32'h74697277;
    localparam int          HALF = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mosi = 1'b0;
    logic         sclk = 1'b0;
    logic         sel = 1'b1;
    logic [B-1:0] tx_data = '0;
    logic         miso;
    logic [B-1:0] rx_data;
    logic         sync;
    logic         frame_err;
    logic [7:0]   err_count;

    spi_frame_slave #(
        .BUFFER_SIZE (B),
        .MSGID       (MID),
        .SYNC_STAGES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mosi      (mosi),
        .miso      (miso),
        .sclk      (sclk),
        .sel       (sel),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .sync      (sync),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    logic [B-1:0] exp_rx = '0;
    int           exp_err = 0;
    bit           busy = 1'b1;
    bit           chk_miso = 1'b0;
    logic         miso_exp = 1'b0;
    logic [63:0]  miso_log = '0;
    int           sync_total = 0;
    int           ferr_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference rule: exactly B bits, and the first four bytes on the wire,
    // read as a little-endian word, equal the message ID.
    function automatic bit model_accept(input logic [63:0] vec, input int n);
        logic [7:0] by [4];
        if (n != B) return 1'b0;
        for (int i = 0; i < 4; i++) by[i] = vec[B-1-8*i -: 8];
        return {by[3], by[2], by[1], by[0]} == MID;
    endfunction

    // Single compare process: steady-state outputs against the model, MISO
    // bits at host sample points, and pulse tallies for frame-end checks.
    always @(negedge clk) begin
        if (rst_n && !busy) begin
            check("idle_rx_data", 64'(rx_data), 64'(exp_rx));
            check("idle_err_count", 64'(err_count), 64'(exp_err));
            check("idle_sync", 64'(sync), 64'd0);
            check("idle_frame_err", 64'(frame_err), 64'd0);
        end
        if (busy) begin
            if (sync === 1'b1) sync_total++;
            if (frame_err === 1'b1) ferr_total++;
        end
        if (chk_miso) begin
            check("miso_bit", 64'(miso), 64'(miso_exp));
            miso_log = {miso_log[62:0], miso};
        end
    end

    // Host transaction: sends the n low bits of vec MSB first. abort_at<n
    // resets the device at that bit; chg_tx inverts tx_data at bit 10.
    task automatic frame(input logic [63:0] vec, input int n, input logic [B-1:0] tx,
                         input bit chg_tx, input int abort_at);
        logic [B-1:0] tx_lat;
        int           s0, f0;
        bit           acc;
        busy = 1'b1;
        s0 = sync_total;
        f0 = ferr_total;
        @(posedge clk);
        tx_data = tx;
        tx_lat  = tx;
        sel     = 1'b0;
        repeat (HALF) @(posedge clk);
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                sel   = 1'b1;
                sclk  = 1'b0;
                repeat (4) @(posedge clk);
                rst_n   = 1'b1;
                exp_rx  = '0;
                exp_err = 0;
                repeat (20) @(posedge clk);
                check("abort_sync_pulses", 64'(sync_total - s0), 64'd0);
                check("abort_ferr_pulses", 64'(ferr_total - f0), 64'd0);
                busy = 1'b0;
                repeat (2) @(posedge clk);
                return;
            end
            if (chg_tx && k == 10) tx_data = ~tx;
            mosi = vec[n-1-k];
            repeat (HALF - 1) @(posedge clk);
            miso_exp = (k < B) ? tx_lat[B-1-k] : 1'b0;
            chk_miso = 1'b1;
            @(posedge clk);
            chk_miso = 1'b0;
            sclk = 1'b1;
            repeat (HALF) @(posedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(posedge clk);
        sel = 1'b1;
        repeat (16) @(posedge clk);
        acc = model_accept(vec, n);
        check("sync_pulses", 64'(sync_total - s0), acc ? 64'd1 : 64'd0);
        check("ferr_pulses", 64'(ferr_total - f0), acc ? 64'd0 : 64'd1);
        if (acc) exp_rx = vec[B-1:0];
        else if (exp_err < 255) exp_err++;
        busy = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    logic [63:0] v;
    logic [B-1:0] t;
    int          nlist [6] = '{46, 47, 48, 48, 49, 50};

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", 64'(rx_data), 64'd0);
        check("reset_sync", 64'(sync), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);
        check("reset_err_count", 64'(err_count), 64'd0);
        check("reset_miso", 64'(miso), 64'd0);
        @(posedge clk);
        rst_n = 1'b1;
        busy  = 1'b0;
        repeat (4) @(posedge clk);

        // Valid frame with literal pins on payload and MISO stream.
        frame(64'h77726974_ABCD, 48, 48'h64617461_1234, 1'b0, 999);
        check("valid_rx_literal", 64'(rx_data), 64'h77726974_ABCD);
        check("valid_miso_literal", 64'(miso_log[47:0]), 64'h64617461_1234);
        check("valid_err_literal", 64'(err_count), 64'd0);

        // Bad header.
        frame(64'h78726974_ABCD, 48, 48'h0, 1'b0, 999);
        check("badhdr_err_literal", 64'(err_count), 64'd1);
        check("badhdr_rx_literal", 64'(rx_data), 64'h77726974_ABCD);

        // Short and long frames with an otherwise good header.
        frame(64'h77726974_ABCD >> 1, 47, 48'hA5A5_5A5A_F00F, 1'b0, 999);
        frame({15'd0, 48'h77726974_ABCD, 1'b1}, 49, 48'h1357_9BDF_2468, 1'b0, 999);
        check("shortlong_err_literal", 64'(err_count), 64'd3);

        // tx_data changes mid-frame; MISO must follow the latched value.
        frame(64'h77726974_0F0F, 48, {B{1'b1}}, 1'b1, 999);
        check("txchg_miso_literal", 64'(miso_log[47:0]), 64'hFFFF_FFFF_FFFF);

        // Randomized frames.
        for (int i = 0; i < 12; i++) begin
            v = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) v[47:16] = 32'h77726974;
            t = B'({$urandom, $urandom});
            frame(v, nlist[$urandom_range(0, 5)], t, 1'b0, 999);
        end

        // Reset mid-frame, then a full valid frame.
        frame(64'h77726974_1111, 48, 48'hCAFE_F00D_BEEF, 1'b0, 20);
        check("abort_rx_literal", 64'(rx_data), 64'd0);
        frame(64'h77726974_2222, 48, 48'h0123_4567_89AB, 1'b0, 999);
        check("after_abort_rx_literal", 64'(rx_data), 64'h77726974_2222);

        // Saturation: 300 frames with no SCLK edges.
        for (int i = 0; i < 300; i++) frame(64'd0, 0, 48'd0, 1'b0, 999);
        check("saturate_err_literal", 64'(err_count), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
